ads131a0x_spi_responder: RTL
============================

// Module: ads131a0x_spi_responder
// PURPOSE
//  Synthesizable SPI slave that emulates the ADS131A0x ADC for on-board loopback and bench
//  testing of the SPI master. Decodes host command words, holds a small register file, and
//  tracks lock/awake state. Paces conversions with SPI_DRDY and returns a response word plus
//  NUM_CH channel words per frame. Sits on the far side of the master's SPI pins.
// PARAMETERS
//  WORD_BITS    24     bits per SPI word; a 16-bit command/response occupies the MSBs, LSBs zero
//  NUM_CH       4      channel words after the response word; frame = (1+NUM_CH)*WORD_BITS bits
//  DRDY_PERIOD  50000  system_clock cycles per conversion (1 kHz at 50 MHz), must be >= 2
//  DEVICE_ID    8'h04  low byte of the READY word (READY = {8'hFF, DEVICE_ID})
// PORTS
//  system_clock  in   1   system clock (50 MHz)
//  reset         in   1   asynchronous, active-high reset
//  spi_sclk      in   1   SPI clock from master, CPOL=0/CPHA=1, asynchronous to system_clock
//  spi_cs        in   1   chip select, active low
//  spi_mosi      in   1   command data from master
//  spi_miso      out  1   response/channel data to master
//  spi_drdy      out  1   data ready, active low
//  frame_done    out  1   1-cycle pulse when a frame completes (CS rising edge)
//  last_cmd      out  16  last fully received command word (debug)
// BEHAVIOUR
//  Sync: spi_sclk, spi_cs and spi_mosi each pass through 2-FF synchronizers. Edges are
//   detected from the synced values, so SCLK high and low phases must each be >= 3 clocks.
//  Reset values: spi_miso=0, spi_drdy=1, frame_done=0, last_cmd=0, locked=1, awake=0,
//   overrun=0, regs[0..15]=0, pending response=READY, sample counter=0, FSM=IDLE.
//  FSM IDLE: spi_miso=0. On CS falling edge: bit_cnt=0, load the frame shift register
//   {resp, ch[0..NUM_CH-1]}, drive its MSB onto spi_miso, set spi_drdy=1, clear overrun,
//   go to SHIFT.
//  FSM SHIFT: on SCLK rising edge, shift out the next bit (no shift before the first
//   falling edge). On SCLK falling edge, sample MOSI into the command shifter. bit_cnt
//   saturates at the frame length; after the last bit, MISO holds 0. On CS rising edge,
//   go to DECODE.
//  FSM DECODE (1 cycle): if bit_cnt >= WORD_BITS, take cmd = first 16 bits received, update
//   last_cmd, and set the pending response for the NEXT frame (below). Otherwise the partial
//   frame is discarded and pending response is unchanged. Pulse frame_done, go to IDLE.
//  Commands (unlisted opcodes are ignored; the NULL response is pending):
//   NULL   16'h0000 -> {8'h22, STAT_1}; STAT_1 = {5'b0, overrun, awake, locked}
//   UNLOCK 16'h0655 -> locked=0, resp 16'h0655
//   LOCK   16'h0555 -> locked=1, resp 16'h0555
//   WAKEUP 16'h0033 -> if unlocked awake=1, resp 16'h0033
//   STANDBY 16'h0022 -> if unlocked awake=0, resp 16'h0022
//   RREG   {3'b001,a[4:0],8'hxx} -> resp {3'b001,a,regs[a]}; a>=16 reads 8'h00
//   WREG   {3'b010,a[4:0],d[7:0]} -> if unlocked and a<16, regs[a]=d;
//          resp {3'b001,a,regs[a]} showing the post-write value
//   RESET  16'h0011 -> same as the reset port, except last_cmd=16'h0011; resp READY
//   Locked: only NULL, UNLOCK, RREG and RESET act; other commands get the NULL response.
//  Conversion: while awake, a counter counts 0..DRDY_PERIOD-1. At wrap, sample counter++,
//   ch[k] = {sample[WORD_BITS-3:0], k[1:0]} (widths truncated), spi_drdy=0. If spi_drdy is
//   already 0 at wrap, overrun=1 and the data is replaced. The channel data loaded at CS
//   fall is frozen for the frame. A wrap coinciding with the CS fall applies after the load,
//   so DRDY stays low. While asleep, the counter holds 0 and spi_drdy=1.
//  Reset mid-frame: all state returns to reset values immediately. The frame in progress is
//   abandoned, and a new frame starts only after the next CS falling edge.
// TESTING
//  1. Release reset, send a 5-word NULL frame: response word 24'hFF0400, channel words 0,
//     last_cmd=0, frame_done pulses once.
//  2. Send UNLOCK then NULL frames: 2nd response 24'h065500; 3rd frame (NULL) gives
//     24'h220000 (locked=0).
//  3. Unlocked: WREG 16'h4B5A, then NULL: response 24'h2B5A00. While locked, WREG 16'h4BFF
//     -> reg 0x0B stays 8'h5A.
//  4. WAKEUP with DRDY_PERIOD=100: spi_drdy falls 100 clocks later. Reading gives ch[k]
//     ending in k, DRDY high at CS fall. Skip one period -> STAT_1[2]=1 in next NULL resp.
//  5. CS rises after 10 bits: no decode, last_cmd unchanged, pending response unchanged.
//  6. Assert reset mid-frame: miso=0, drdy=1 within 1 clock. Next frame returns READY.

Source files
------------

// File: rtl/ads131a0x_spi_responder.sv
// ADS131A0x SPI slave emulator: command decode, register file, lock/awake state,
// DRDY-paced synthetic conversions and a {response, channel words} readback frame.
module ads131a0x_spi_responder #(
  parameter int unsigned WORD_BITS   = 24,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DRDY_PERIOD = 50000,
  parameter logic [7:0]  DEVICE_ID   = 8'h04
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_drdy,
  output logic        frame_done,
  output logic [15:0] last_cmd
);

  localparam int unsigned FRAME_BITS = (1 + NUM_CH) * WORD_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned PER_W      = $clog2(DRDY_PERIOD);
  localparam int unsigned SMP_W      = WORD_BITS - 2;

  localparam logic [CNT_W-1:0] FRAME_C  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CMD_C    = CNT_W'(16);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(DRDY_PERIOD - 1);
  localparam logic [15:0]      READY    = {8'hFF, DEVICE_ID};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;

  logic [1:0]            sclk_s, cs_s, mosi_s;
  logic                  sclk_d, cs_d;
  logic [1:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] frame_sr, frame_load;
  logic [15:0]           cmd_sr, resp_reg, resp16;
  logic                  resp_null;
  logic                  locked, awake, overrun, ch_valid;
  logic [SMP_W-1:0]      sample;
  logic [PER_W-1:0]      per_cnt;
  logic [7:0]            regs [16];
  logic [7:0]            stat1, rd_data;
  logic [4:0]            addr;
  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, soft_rst;

  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[1] & sclk_d;
  assign cs_rise   = cs_s[1] & ~cs_d;
  assign cs_fall   = ~cs_s[1] & cs_d;

  assign addr     = cmd_sr[12:8];
  assign rd_data  = addr[4] ? 8'h00 : regs[addr[3:0]];
  assign stat1    = {5'b0, overrun, awake, locked};
  // A pending NULL response is resolved at frame start so it reports live status.
  assign resp16   = resp_null ? {8'h22, stat1} : resp_reg;
  assign soft_rst = (state == DECODE) && (bit_cnt >= WORD_C) && (cmd_sr == 16'h0011);

  always_comb begin
    frame_load = '0;
    frame_load[FRAME_BITS-1 -: 16] = resp16;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      frame_load[(NUM_CH-1-k)*WORD_BITS +: WORD_BITS] = ch_valid ? {sample, 2'(k)} : '0;
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      sclk_s     <= '0;
      cs_s       <= '0;
      mosi_s     <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b0;
      state      <= IDLE;
      bit_cnt    <= '0;
      frame_sr   <= '0;
      cmd_sr     <= '0;
      spi_miso   <= 1'b0;
      spi_drdy   <= 1'b1;
      frame_done <= 1'b0;
      last_cmd   <= '0;
      locked     <= 1'b1;
      awake      <= 1'b0;
      overrun    <= 1'b0;
      resp_reg   <= READY;
      resp_null  <= 1'b0;
      sample     <= '0;
      ch_valid   <= 1'b0;
      per_cnt    <= '0;
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      sclk_s     <= {sclk_s[0], spi_sclk};
      cs_s       <= {cs_s[0], spi_cs};
      mosi_s     <= {mosi_s[0], spi_mosi};
      sclk_d     <= sclk_s[1];
      cs_d       <= cs_s[1];
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (cs_fall) begin
            bit_cnt  <= '0;
            frame_sr <= frame_load;
            spi_miso <= frame_load[FRAME_BITS-1];
            spi_drdy <= 1'b1;
            overrun  <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= DECODE;
          end else begin
            if (sclk_rise && bit_cnt != '0) begin
              frame_sr <= frame_sr << 1;
              spi_miso <= (bit_cnt < FRAME_C) ? frame_sr[FRAME_BITS-2] : 1'b0;
            end
            if (sclk_fall && bit_cnt < FRAME_C) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt < CMD_C) cmd_sr <= {cmd_sr[14:0], mosi_s[1]};
            end
          end
        end
        DECODE: begin
          frame_done <= 1'b1;
          state      <= IDLE;
          if (bit_cnt >= WORD_C) begin
            last_cmd  <= cmd_sr;
            resp_null <= 1'b0;
            if (cmd_sr == 16'h0011) begin
              locked   <= 1'b1;
              awake    <= 1'b0;
              overrun  <= 1'b0;
              resp_reg <= READY;
              sample   <= '0;
              ch_valid <= 1'b0;
              per_cnt  <= '0;
              spi_drdy <= 1'b1;
              for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
            end else if (cmd_sr == 16'h0655) begin
              locked   <= 1'b0;
              resp_reg <= 16'h0655;
            end else if (cmd_sr[15:13] == 3'b001) begin
              resp_reg <= {3'b001, addr, rd_data};
            end else if (locked) begin
              resp_null <= 1'b1;
            end else if (cmd_sr == 16'h0555) begin
              locked   <= 1'b1;
              resp_reg <= 16'h0555;
            end else if (cmd_sr == 16'h0033) begin
              awake    <= 1'b1;
              resp_reg <= 16'h0033;
            end else if (cmd_sr == 16'h0022) begin
              awake    <= 1'b0;
              resp_reg <= 16'h0022;
            end else if (cmd_sr[15:13] == 3'b010) begin
              if (!addr[4]) regs[addr[3:0]] <= cmd_sr[7:0];
              resp_reg <= {3'b001, addr, addr[4] ? 8'h00 : cmd_sr[7:0]};
            end else begin
              resp_null <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the frame FSM so a wrap on the CS-fall cycle wins over the DRDY release.
      if (!soft_rst) begin
        if (awake) begin
          if (per_cnt == PER_LAST) begin
            per_cnt  <= '0;
            sample   <= sample + SMP_W'(1);
            ch_valid <= 1'b1;
            spi_drdy <= 1'b0;
            if (!spi_drdy) overrun <= 1'b1;
          end else begin
            per_cnt <= per_cnt + PER_W'(1);
          end
        end else begin
          per_cnt  <= '0;
          spi_drdy <= 1'b1;
        end
      end
    end
  end

endmodule
